// File: rtl/input_conditioner.sv
// Button input conditioner: per-channel 2-flop sync, counter debounce,
// press/release edge pulses and a hold-to-repeat FSM.

module input_conditioner_ch #(
  parameter int DEBOUNCE_CYCLES = 60000,
  parameter int REPEAT_DELAY    = 4800000,
  parameter int REPEAT_PERIOD   = 1200000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic lvl,
  output logic prs,
  output logic rls,
  output logic rpt
);
  typedef enum logic [1:0] {RELEASED, HELD_DELAY, HELD_REPEAT} state_e;

  localparam logic [19:0] STAB_LAST   = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0] DELAY_LAST  = 24'(REPEAT_DELAY - 1);
  localparam logic [23:0] PERIOD_LAST = 24'(REPEAT_PERIOD - 1);

  logic [1:0]  sync_q, sync_d;
  logic [19:0] stab_q, stab_d;
  logic [23:0] hold_q, hold_d;
  logic        lvl_q, lvl_d, prs_q, prs_d, rls_q, rls_d, rpt_q, rpt_d;
  state_e      state_q, state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      stab_q  <= '0;
      hold_q  <= '0;
      lvl_q   <= 1'b0;
      prs_q   <= 1'b0;
      rls_q   <= 1'b0;
      rpt_q   <= 1'b0;
      state_q <= RELEASED;
    end else begin
      sync_q  <= sync_d;
      stab_q  <= stab_d;
      hold_q  <= hold_d;
      lvl_q   <= lvl_d;
      prs_q   <= prs_d;
      rls_q   <= rls_d;
      rpt_q   <= rpt_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    sync_d  = {sync_q[0], raw};
    stab_d  = '0;
    lvl_d   = lvl_q;
    prs_d   = 1'b0;
    rls_d   = 1'b0;
    rpt_d   = 1'b0;
    state_d = state_q;
    hold_d  = hold_q;

    if (sync_q[1] != lvl_q) begin
      if (stab_q == STAB_LAST) begin
        lvl_d = ~lvl_q;
        prs_d = ~lvl_q;
        rls_d = lvl_q;
      end else begin
        stab_d = stab_q + 20'd1;
      end
    end

    // Level edges take priority so a release always suppresses a coincident repeat.
    if (prs_d) begin
      state_d = HELD_DELAY;
      hold_d  = '0;
    end else if (rls_d) begin
      state_d = RELEASED;
      hold_d  = '0;
    end else begin
      case (state_q)
        HELD_DELAY: begin
          if (hold_q == DELAY_LAST) begin
            rpt_d   = 1'b1;
            hold_d  = '0;
            state_d = HELD_REPEAT;
          end else begin
            hold_d = hold_q + 24'd1;
          end
        end
        HELD_REPEAT: begin
          if (hold_q == PERIOD_LAST) begin
            rpt_d  = 1'b1;
            hold_d = '0;
          end else begin
            hold_d = hold_q + 24'd1;
          end
        end
        default: hold_d = '0;
      endcase
    end
  end

  assign lvl = lvl_q;
  assign prs = prs_q;
  assign rls = rls_q;
  assign rpt = rpt_q;
endmodule

module input_conditioner #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 60000,
  parameter int REPEAT_DELAY    = 4800000,
  parameter int REPEAT_PERIOD   = 1200000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    input_conditioner_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .raw  (btn_raw[i]),
      .lvl  (btn_level[i]),
      .prs  (btn_press[i]),
      .rls  (btn_release[i]),
      .rpt  (btn_repeat[i])
    );
  end
endmodule

// File: tb/tb_input_conditioner.sv
// Directed + randomized bench for input_conditioner against an elapsed-time reference model.

module tb_input_conditioner;
  localparam int N  = 5;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_repeat;
  int           n_tests = 0;
  int           n_fail = 0;
  int           cyc = 0;

  input_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat)
  );

  always #5 clk = ~clk;

  // Reference: raw seen two edges late; level flips after D consecutive differing
  // samples; repeats at RD + k*RP cycles after the press while still held.
  logic [N-1:0] m_lvl, m_prs, m_rls, m_rpt, m_d1, m_d2;
  int           m_run[N];
  int           m_held[N];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_lvl  <= '0;
      m_prs  <= '0;
      m_rls  <= '0;
      m_rpt  <= '0;
      m_d1   <= '0;
      m_d2   <= '0;
      m_run  <= '{default: 0};
      m_held <= '{default: 0};
    end else begin : step
      logic [N-1:0] lv, p, r, rp;
      int run[N];
      int held[N];
      lv = m_lvl; run = m_run; held = m_held;
      p = '0; r = '0; rp = '0;
      for (int i = 0; i < N; i++) begin
        if (m_d2[i] != lv[i]) run[i]++;
        else run[i] = 0;
        if (run[i] == D) begin
          run[i] = 0;
          lv[i] = m_d2[i];
          if (lv[i]) begin
            p[i] = 1'b1;
            held[i] = 0;
          end else begin
            r[i] = 1'b1;
          end
        end else if (lv[i]) begin
          held[i]++;
          if (held[i] >= RD && (held[i] - RD) % RP == 0) rp[i] = 1'b1;
        end
      end
      m_lvl  <= lv;
      m_prs  <= p;
      m_rls  <= r;
      m_rpt  <= rp;
      m_run  <= run;
      m_held <= held;
      m_d2   <= m_d1;
      m_d1   <= btn_raw;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cyc_chk();
    #1;
    n_tests++;
    assert ({btn_level, btn_press, btn_release, btn_repeat} === {m_lvl, m_prs, m_rls, m_rpt})
    else begin
      n_fail++;
      $error("FAIL model cyc=%0d got lvl/prs/rls/rpt=%b/%b/%b/%b exp=%b/%b/%b/%b", cyc,
             btn_level, btn_press, btn_release, btn_repeat, m_lvl, m_prs, m_rls, m_rpt);
    end
    n_tests++;
    assert (((btn_press & btn_release) | (btn_press & btn_repeat) | (btn_release & btn_repeat)) === {N{1'b0}})
    else begin
      n_fail++;
      $error("FAIL excl cyc=%0d got prs/rls/rpt=%b/%b/%b exp no overlap", cyc, btn_press, btn_release, btn_repeat);
    end
  endtask

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] bit_at(input int k, input bit on);
    logic [N-1:0] v;
    v = '0;
    if (on) v[k] = 1'b1;
    return v;
  endfunction

  // Reset, settle, and leave time at cycle 0 (just after an edge).
  task automatic start();
    reset = 1'b1;
    btn_raw = '0;
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    cyc = 0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_lvl", btn_level, '0);
    chk("rst_pulses", btn_press | btn_release | btn_repeat, '0);

    // Clean press on bit 0
    start();
    btn_raw = 5'b00001;
    cyc_chk();
    for (int c = 1; c <= 12; c++) begin
      tick(); cyc_chk();
      chk("p1up_prs", btn_press, bit_at(0, c == 6));
      chk("p1up_lvl", btn_level, bit_at(0, c >= 6));
    end

    // Short glitch on bit 1
    start();
    btn_raw = 5'b00010;
    cyc_chk();
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 3) btn_raw = '0;
      cyc_chk();
      chk("glitch_lvl", btn_level, '0);
      chk("glitch_edges", btn_press | btn_release, '0);
    end

    // Hold bit 4 for 30 cycles: press, repeats, release
    start();
    btn_raw = 5'b10000;
    cyc_chk();
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 30) btn_raw = '0;
      cyc_chk();
      chk("hold_prs", btn_press, bit_at(4, c == 6));
      chk("hold_rpt", btn_repeat, bit_at(4, c >= 16 && c <= 34 && (c - 16) % 3 == 0));
      chk("hold_rls", btn_release, bit_at(4, c == 36));
    end

    // Release coinciding with a repeat slot (cycle 37) on bit 3
    start();
    btn_raw = 5'b01000;
    cyc_chk();
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 31) btn_raw = '0;
      cyc_chk();
      chk("race_rpt", btn_repeat, bit_at(3, c >= 16 && c <= 34 && (c - 16) % 3 == 0));
      chk("race_rls", btn_release, bit_at(3, c == 37));
    end

    // All channels together
    start();
    btn_raw = '1;
    cyc_chk();
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (c == 20) btn_raw = '0;
      cyc_chk();
      chk("all_prs", btn_press, (c == 6) ? '1 : '0);
      chk("all_rls", btn_release, (c == 26) ? '1 : '0);
      chk("all_rpt", btn_repeat, (c >= 16 && c < 26 && (c - 16) % 3 == 0) ? '1 : '0);
    end

    // Reset mid-debounce with bit 2 held
    start();
    btn_raw = 5'b00100;
    cyc_chk();
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 4) reset = 1'b1;
      if (c == 5) reset = 1'b0;
      cyc_chk();
      if (c == 4) chk("rst_mid_all", btn_level | btn_press | btn_release | btn_repeat, '0);
      if (c == 6) chk("rst_first_pulses", btn_press | btn_release | btn_repeat, '0);
      chk("rst_prs", btn_press, bit_at(2, c == 11));
      chk("rst_lvl2", btn_level, bit_at(2, c >= 11));
    end

    // Randomized toggling with occasional reset pulses
    start();
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 11) == 0) btn_raw[i] = ~btn_raw[i];
      reset = ($urandom_range(0, 399) == 0);
      cyc_chk();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter N_BTN, default 5: number of independent button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 60000: consecutive stable clk cycles required to accept a level change (5 ms at 12 MHz); legal range 2..2^20-1.
REQ-003 Parameter REPEAT_DELAY, default 4800000: clk cycles from press pulse to first repeat pulse; legal range 2..2^24-1.
REQ-004 Parameter REPEAT_PERIOD, default 1200000: clk cycles between subsequent repeat pulses; legal range 2..2^24-1.
REQ-005 clk  input  1  system clock, 12 MHz from the HSOSC divider; all state advances on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 btn_raw  input  N_BTN  raw asynchronous button levels, 1 = pressed; bit order {enter, p2_down, p2_up, p1_down, p1_up}, with bit 0 = p1_up.
REQ-008 btn_level  output  N_BTN  debounced button level.
REQ-009 btn_press  output  N_BTN  one-cycle pulse on accepted 0->1 change.
REQ-010 btn_release  output  N_BTN  one-cycle pulse on accepted 1->0 change.
REQ-011 btn_repeat  output  N_BTN  one-cycle auto-repeat pulse while held.

Function
REQ-012 Each channel SHALL pass btn_raw through a two-flop synchronizer; only the second-stage output (sync) feeds further logic.
REQ-013 Each channel SHALL keep a 20-bit stability counter: cleared in any cycle where sync == btn_level; incremented in any cycle where sync != btn_level.
REQ-014 When sync != btn_level and the counter equals DEBOUNCE_CYCLES-1, btn_level SHALL toggle on that edge and the counter SHALL clear.
REQ-015 Total latency raw edge -> btn_level edge SHALL be exactly 2 + DEBOUNCE_CYCLES clk cycles for a clean step.
REQ-016 A sync glitch shorter than DEBOUNCE_CYCLES cycles SHALL clear the counter and leave btn_level, btn_press and btn_release unchanged.
REQ-017 btn_press (btn_release) SHALL be high for exactly the single cycle in which btn_level is first 1 (first 0), i.e. registered and coincident with the new level.
REQ-018 Per-channel repeat FSM states: RELEASED, HELD_DELAY, HELD_REPEAT; a 24-bit hold counter.
REQ-019 RELEASED -> HELD_DELAY on the btn_press cycle, hold counter = 0.
REQ-020 In HELD_DELAY the hold counter increments each cycle; when it reaches REPEAT_DELAY the FSM SHALL assert btn_repeat for one cycle, clear the counter and enter HELD_REPEAT.
REQ-021 In HELD_REPEAT, btn_repeat SHALL pulse one cycle each time the counter reaches REPEAT_PERIOD, with the counter clearing on that cycle.
REQ-022 Any state -> RELEASED on the btn_release cycle; if a repeat pulse would coincide, release SHALL win and btn_repeat SHALL stay 0.
REQ-023 btn_press, btn_release and btn_repeat of one channel SHALL be mutually exclusive in any cycle.
REQ-024 Channels SHALL be fully independent; simultaneous events on any subset SHALL produce the same per-channel outputs as isolated events.
REQ-025 Counters SHALL never wrap: the stability counter is bounded by REQ-014, and the hold counter by REQ-020 and REQ-021.

Reset
REQ-026 While reset = 1, the synchronizer flops, btn_level, all counters and all pulse outputs SHALL be 0, and every FSM SHALL be in RELEASED, independent of clk.
REQ-027 Reset asserted mid-debounce or mid-hold SHALL discard all progress; after deassertion, a button still held SHALL yield btn_press exactly 2 + DEBOUNCE_CYCLES cycles later.
REQ-028 No pulse output SHALL be asserted in the first clk cycle after reset deassertion.

Verification (bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, N_BTN=5)
REQ-029 btn_raw[0] steps 0->1 at cycle 0 and holds -> btn_level[0]=1 and btn_press[0] pulse at cycle 6; no other bit changes.
REQ-030 btn_raw[1] high for 3 cycles then low -> btn_level[1], btn_press[1] and btn_release[1] stay 0 throughout.
REQ-031 btn_raw[4] held 30 cycles from cycle 0 -> press at 6; repeat at 16, 19, 22, 25, 28, 31, 34; release at 36; no repeat at or after 36.
REQ-032 btn_raw = 5'b11111 at cycle 0 -> all five btn_press bits pulse together at cycle 6; with all five released at cycle 20, all five btn_release bits pulse at cycle 26.
REQ-033 btn_raw[2] held; reset pulsed at cycle 4 for 1 cycle -> outputs 0 during reset; btn_press[2] at 2 + 4 = 6 cycles after deassertion.
REQ-034 Release timed so that btn_level falls in the same cycle a repeat would fire -> btn_release = 1 and btn_repeat = 0 in that cycle.
